// File: rtl/psram_resp.sv
// psram_resp: PSRAM target model with command/address/latency/data FSM and byte memory
module psram_resp #(
  parameter int DEPTH = 256,
  parameter logic [7:0] RCMD = 8'h20,
  parameter logic [7:0] WCMD = 8'hA0,
  parameter logic [7:0] CRCMD = 8'h40,
  parameter logic [7:0] CWCMD = 8'hC0,
  parameter int LC = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     psram_sck_i,
  input  logic                     psram_ce_i,
  input  logic [7:0]               psram_io_in_i,
  output logic [7:0]               psram_io_out_o,
  output logic [7:0]               psram_io_en_o,
  input  logic                     psram_dqs_in_i,
  output logic                     psram_dqs_out_o,
  output logic                     psram_dqs_en_o,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
  output logic [7:0]               dbg_data_o,
  output logic                     busy_o,
  output logic                     cmd_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = AW < 3 ? 3 : AW;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, LAT, WDATA, RDATA, DROP} state_t;
  state_t state, state_n;
  logic [10:0] s1, s2;
  logic [1:0] vld;
  logic sck_q, sck_s, ce_s, dqs_s, act, rise_a, fall_a, got, cmd_ok, is_wr, is_mr;
  logic [7:0] io_s, cmd, cnt, rd_byte, rd_data;
  logic dqs_r;
  logic [RW-1:0] addr;
  logic [7:0] mem [DEPTH];
  logic [7:0] mr [8];
  assign {sck_s, ce_s, dqs_s, io_s} = s2;
  assign act = (sck_s ^ sck_q) & ~ce_s;
  assign rise_a = act & sck_s;
  assign fall_a = act & ~sck_s;
  assign cmd_ok = cmd == RCMD || cmd == WCMD || cmd == CRCMD || cmd == CWCMD;
  assign is_wr = cmd == WCMD || cmd == CWCMD;
  assign is_mr = cmd == CRCMD || cmd == CWCMD;
  assign rd_data = is_mr ? mr[addr[2:0]] : mem[addr[AW-1:0]];
  assign dbg_data_o = mem[dbg_addr_i];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      s1 <= '0;
      s2 <= '0;
      sck_q <= 1'b0;
      vld <= '0;
    end else begin
      s1 <= {psram_sck_i, psram_ce_i, psram_dqs_in_i, psram_io_in_i};
      s2 <= s1;
      sck_q <= s2[10];
      vld <= {vld[0], 1'b1};
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = vld[1] && !ce_s ? CMD : IDLE;
      CMD: if (got && fall_a) state_n = cmd_ok ? ADDR : DROP;
      ADDR: if (act && cnt == 8'd3) state_n = is_wr ? WDATA : LC == 0 ? RDATA : LAT;
      LAT: if (rise_a && cnt == 8'(LC - 1)) state_n = RDATA;
      default: state_n = state;
    endcase
    if (state != IDLE && ce_s) state_n = IDLE;
  end
  always_comb begin
    busy_o = state != IDLE;
    psram_dqs_en_o = state == RDATA;
    psram_io_en_o = psram_dqs_en_o ? 8'hFF : 8'h00;
    psram_io_out_o = psram_dqs_en_o ? rd_byte : 8'h00;
    psram_dqs_out_o = psram_dqs_en_o & dqs_r;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cmd <= '0;
      got <= 1'b0;
      cnt <= '0;
      addr <= '0;
      rd_byte <= '0;
      dqs_r <= 1'b0;
      cmd_err_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int i = 1; i < 8; i++) mr[i] <= '0;
      mr[0] <= 8'(LC);
    end else begin
      cmd_err_o <= state == CMD && state_n == DROP;
      got <= state == CMD && (got || rise_a);
      if (state == CMD && rise_a && !got) cmd <= io_s;
      cnt <= state_n != state ? '0 : ((state == ADDR && act) || (state == LAT && rise_a)) ? cnt + 8'd1 : cnt;
      if (state == ADDR && act) addr <= RW'({addr, io_s});
      if ((state == WDATA || state == RDATA) && act) addr <= addr + 1'b1;
      if (state == WDATA && act && !dqs_s && is_mr) mr[addr[2:0]] <= io_s;
      if (state == WDATA && act && !dqs_s && !is_mr) mem[addr[AW-1:0]] <= io_s;
      rd_byte <= state != RDATA ? 8'h00 : act ? rd_data : rd_byte;
      dqs_r <= state == RDATA && (dqs_r ^ act);
    end
endmodule
